vlib_piped_adder_tree: RTL and testbench

VLIB_PIPED_ADDER_TREE -- requirements
Module: vlib_piped_adder_tree

---
 rtl/vlib_piped_adder_tree_if.sv | 25 ++
 rtl/vlib_piped_adder_tree.sv | 112 +++++++++++
 tb/tb_vlib_piped_adder_tree.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vlib_piped_adder_tree_if.sv
// vlib_piped_adder_tree_if: beat-in / result-out handshake bundle of the adder tree
interface vlib_piped_adder_tree_if #(
  parameter int ATOMIC_C = 8,
  parameter int BITWIDTH = 8,
  parameter int ACC_BITS = 8
);
  localparam int OUT_W = BITWIDTH + $clog2(ATOMIC_C) + ACC_BITS;
  logic                         IN_VALID;
  logic                         IN_READY;
  logic [ATOMIC_C*BITWIDTH-1:0] IN;
  logic                         IN_LAST;
  logic                         ACC_MODE;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic signed [OUT_W-1:0]      RES;
  logic                         OUT_OVF;
  modport master (
    output IN_VALID, IN, IN_LAST, ACC_MODE, OUT_READY,
    input  IN_READY, OUT_VALID, RES, OUT_OVF
  );
  modport slave (
    input  IN_VALID, IN, IN_LAST, ACC_MODE, OUT_READY,
    output IN_READY, OUT_VALID, RES, OUT_OVF
  );
endinterface

// File: rtl/vlib_piped_adder_tree.sv
// vlib_piped_adder_tree: pipelined signed adder tree with saturating group accumulator
module vlib_piped_adder_tree #(
  parameter int ATOMIC_C   = 8,
  parameter int BITWIDTH   = 8,
  parameter int PIPE_EVERY = 1,
  parameter int ACC_BITS   = 8
) (
  input logic                    CLK,
  input logic                    NRST,
  vlib_piped_adder_tree_if.slave bus
);
  localparam int NUM_LEVELS = $clog2(ATOMIC_C);
  localparam int SUM_W      = BITWIDTH + NUM_LEVELS;
  localparam int OUT_W      = SUM_W + ACC_BITS;
  // a stride longer than the tree places no register inside it
  localparam int STRIDE     = (PIPE_EVERY == 0) ? NUM_LEVELS + 1 : PIPE_EVERY;
  typedef enum logic {IDLE, OPEN} state_t;
  state_t                  r_state;
  logic                    r_out_valid;
  logic                    r_ovf;
  logic                    r_sticky;
  logic signed [OUT_W-1:0] r_res;
  logic signed [OUT_W-1:0] r_acc;
  logic                    w_en;
  assign w_en          = !r_out_valid | bus.OUT_READY;
  assign bus.IN_READY  = w_en & NRST;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.RES       = r_res;
  assign bus.OUT_OVF   = r_ovf;
  for (genvar k = 0; k <= NUM_LEVELS; k++) begin : g_lvl
    logic signed [SUM_W-1:0] w_o [ATOMIC_C>>k];
    logic                    w_v;
    logic                    w_l;
    logic                    w_m;
    if (k == 0) begin : g_in
      for (genvar j = 0; j < ATOMIC_C; j++) begin : g_lane
        assign w_o[j] = {{NUM_LEVELS{bus.IN[(j+1)*BITWIDTH-1]}}, bus.IN[j*BITWIDTH +: BITWIDTH]};
      end
      assign w_v = bus.IN_VALID;
      assign w_l = bus.IN_LAST;
      assign w_m = bus.ACC_MODE;
    end else begin : g_add
      logic signed [SUM_W-1:0] w_s [ATOMIC_C>>k];
      for (genvar j = 0; j < (ATOMIC_C >> k); j++) begin : g_pair
        assign w_s[j] = g_lvl[k-1].w_o[2*j] + g_lvl[k-1].w_o[2*j+1];
      end
      if (k % STRIDE == 0) begin : g_reg
        logic signed [SUM_W-1:0] r_s [ATOMIC_C>>k];
        logic                    r_v;
        logic                    r_l;
        logic                    r_m;
        // pipeline stage: partial sums travel with their valid/last/mode tags
        always_ff @(posedge CLK)
          if (!NRST) r_v <= 1'b0;
          else if (w_en) begin
            r_s <= w_s;
            r_v <= g_lvl[k-1].w_v;
            r_l <= g_lvl[k-1].w_l;
            r_m <= g_lvl[k-1].w_m;
          end
        assign w_o = r_s;
        assign w_v = r_v;
        assign w_l = r_l;
        assign w_m = r_m;
      end else begin : g_comb
        assign w_o = w_s;
        assign w_v = g_lvl[k-1].w_v;
        assign w_l = g_lvl[k-1].w_l;
        assign w_m = g_lvl[k-1].w_m;
      end
    end
  end
  logic signed [SUM_W-1:0] w_tsum;
  logic signed [OUT_W-1:0] w_ext;
  logic signed [OUT_W-1:0] w_base;
  logic signed [OUT_W-1:0] w_sat;
  logic        [OUT_W:0]   w_full;
  logic                    w_tv;
  logic                    w_close;
  logic                    w_ovf;
  assign w_tsum  = g_lvl[NUM_LEVELS].w_o[0];
  assign w_tv    = g_lvl[NUM_LEVELS].w_v;
  assign w_close = !g_lvl[NUM_LEVELS].w_m | g_lvl[NUM_LEVELS].w_l;
  assign w_ext   = {{ACC_BITS{w_tsum[SUM_W-1]}}, w_tsum};
  assign w_base  = (r_state == OPEN) ? r_acc : '0;
  assign w_full  = {w_base[OUT_W-1], w_base} + {w_ext[OUT_W-1], w_ext};
  assign w_ovf   = w_full[OUT_W] ^ w_full[OUT_W-1];
  assign w_sat   = w_ovf ? {w_full[OUT_W], {(OUT_W-1){~w_full[OUT_W]}}} : w_full[OUT_W-1:0];
  // group FSM: fold tree results into the accumulator, emit on group close
  always_ff @(posedge CLK)
    if (!NRST) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_tv & w_close;
      if (w_tv && w_close) begin
        r_res    <= w_sat;
        r_ovf    <= r_sticky | w_ovf;
        r_acc    <= '0;
        r_sticky <= 1'b0;
        r_state  <= IDLE;
      end else if (w_tv) begin
        r_acc    <= w_sat;
        r_sticky <= r_sticky | w_ovf;
        r_state  <= OPEN;
      end
    end
endmodule

// File: tb/tb_vlib_piped_adder_tree.sv
// tb_vlib_piped_adder_tree: directed checks of tree sums, latency, accumulation, stall and reset
module tb_vlib_piped_adder_tree;
  logic CLK = 1'b0;
  logic NRST = 1'b0;
  int checks = 0;
  int errors = 0;
  logic signed [18:0] q0 [$];

  vlib_piped_adder_tree_if #(.ATOMIC_C(8), .BITWIDTH(8), .ACC_BITS(8)) b0 ();
  vlib_piped_adder_tree_if #(.ATOMIC_C(8), .BITWIDTH(8), .ACC_BITS(1)) b1 ();

  vlib_piped_adder_tree #(.ATOMIC_C(8), .BITWIDTH(8), .PIPE_EVERY(1), .ACC_BITS(8)) dut0 (
    .CLK(CLK), .NRST(NRST), .bus(b0));
  vlib_piped_adder_tree #(.ATOMIC_C(8), .BITWIDTH(8), .PIPE_EVERY(4), .ACC_BITS(1)) dut1 (
    .CLK(CLK), .NRST(NRST), .bus(b1));

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (NRST && b0.OUT_VALID && b0.OUT_READY) q0.push_back(b0.RES);

  function automatic logic [63:0] fill(input int v);
    fill = {8{v[7:0]}};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive0(input logic [63:0] d, input logic m, input logic l);
    logic ok;
    ok = 1'b0;
    b0.IN = d; b0.ACC_MODE = m; b0.IN_LAST = l; b0.IN_VALID = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK);
      ok = b0.IN_READY;
      tick();
    end
    b0.IN_VALID = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL drive0_accept: got %b expected 1", ok); end
  endtask

  task automatic drive1(input logic [63:0] d, input logic m, input logic l);
    logic ok;
    ok = 1'b0;
    b1.IN = d; b1.ACC_MODE = m; b1.IN_LAST = l; b1.IN_VALID = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge CLK);
      ok = b1.IN_READY;
      tick();
    end
    b1.IN_VALID = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL drive1_accept: got %b expected 1", ok); end
  endtask

  task automatic wait0(output int n);
    n = 1;
    while (b0.OUT_VALID !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic wait1(output int n);
    n = 1;
    while (b1.OUT_VALID !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset;
    NRST = 1'b0;
    b0.IN_VALID = 1'b0; b0.IN = '0; b0.IN_LAST = 1'b0; b0.ACC_MODE = 1'b0; b0.OUT_READY = 1'b1;
    b1.IN_VALID = 1'b0; b1.IN = '0; b1.IN_LAST = 1'b0; b1.ACC_MODE = 1'b0; b1.OUT_READY = 1'b1;
    tick();
    tick();
    checks += 8;
    if (b0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b expected 0", b0.OUT_VALID); end
    if (b0.RES !== 19'sd0) begin errors++; $display("FAIL reset_res0: got %0d expected 0", b0.RES); end
    if (b0.OUT_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf0: got %b expected 0", b0.OUT_OVF); end
    if (b0.IN_READY !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", b0.IN_READY); end
    if (b1.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", b1.OUT_VALID); end
    if (b1.RES !== 12'sd0) begin errors++; $display("FAIL reset_res1: got %0d expected 0", b1.RES); end
    if (b1.OUT_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf1: got %b expected 0", b1.OUT_OVF); end
    if (b1.IN_READY !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", b1.IN_READY); end
    NRST = 1'b1;
    #1;
    checks++;
    if (b0.IN_READY !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", b0.IN_READY); end
  endtask

  task automatic test_passthrough;
    logic [63:0] d;
    logic signed [31:0] res;
    int n;
    tick();
    drive0(fill(127), 1'b0, 1'b0);
    wait0(n);
    res = b0.RES;
    checks += 3;
    if (n !== 4) begin errors++; $display("FAIL latency_127: got %0d expected 4", n); end
    if (res !== 1016) begin errors++; $display("FAIL sum_127: got %0d expected 1016", res); end
    if (b0.OUT_OVF !== 1'b0) begin errors++; $display("FAIL ovf_127: got %b expected 0", b0.OUT_OVF); end
    tick();
    checks++;
    if (b0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", b0.OUT_VALID); end
    drive0(fill(-128), 1'b0, 1'b1);
    wait0(n);
    res = b0.RES;
    checks++;
    if (res !== -1024) begin errors++; $display("FAIL sum_m128: got %0d expected -1024", res); end
    tick();
    d = {4{8'h80, 8'h7f}};
    drive0(d, 1'b0, 1'b0);
    wait0(n);
    res = b0.RES;
    checks++;
    if (res !== -4) begin errors++; $display("FAIL sum_alt: got %0d expected -4", res); end
    tick();
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(j - 3);
    drive0(d, 1'b0, 1'b0);
    wait0(n);
    res = b0.RES;
    checks++;
    if (res !== 4) begin errors++; $display("FAIL sum_ramp: got %0d expected 4", res); end
    tick();
  endtask

  task automatic test_accumulate;
    logic signed [31:0] res;
    int n;
    int base;
    base = q0.size();
    drive0(fill(1), 1'b1, 1'b0);
    drive0(fill(1), 1'b1, 1'b0);
    checks++;
    if (b0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL acc_early_valid: got %b expected 0", b0.OUT_VALID); end
    drive0(fill(1), 1'b1, 1'b1);
    wait0(n);
    res = b0.RES;
    checks += 3;
    if (n !== 4) begin errors++; $display("FAIL acc_latency: got %0d expected 4", n); end
    if (res !== 24) begin errors++; $display("FAIL acc_sum: got %0d expected 24", res); end
    if (b0.OUT_OVF !== 1'b0) begin errors++; $display("FAIL acc_ovf: got %b expected 0", b0.OUT_OVF); end
    tick();
    checks++;
    if (q0.size() - base !== 1) begin errors++; $display("FAIL acc_count: got %0d expected 1", q0.size() - base); end
    drive0(fill(2), 1'b1, 1'b0);
    drive0(fill(3), 1'b0, 1'b0);
    wait0(n);
    res = b0.RES;
    checks++;
    if (res !== 40) begin errors++; $display("FAIL mode0_close: got %0d expected 40", res); end
    tick();
    drive0(fill(1), 1'b0, 1'b0);
    wait0(n);
    res = b0.RES;
    checks++;
    if (res !== 8) begin errors++; $display("FAIL after_close: got %0d expected 8", res); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic signed [18:0] snap;
    logic signed [31:0] res;
    q0.delete();
    fork
      begin
        for (int k = 1; k <= 8; k++) drive0(fill(k), 1'b0, 1'b0);
      end
      begin
        repeat (5) tick();
        checks++;
        if (b0.OUT_VALID !== 1'b1) begin errors++; $display("FAIL stall_start_valid: got %b expected 1", b0.OUT_VALID); end
        snap = b0.RES;
        b0.OUT_READY = 1'b0;
        repeat (5) begin
          tick();
          checks += 3;
          if (b0.OUT_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", b0.OUT_VALID); end
          if (b0.RES !== snap) begin errors++; $display("FAIL stall_hold: got %0d expected %0d", b0.RES, snap); end
          if (b0.IN_READY !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", b0.IN_READY); end
        end
        b0.OUT_READY = 1'b1;
      end
    join
    for (int t = 0; t < 100 && q0.size() < 8; t++) tick();
    repeat (5) tick();
    checks++;
    if (q0.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", q0.size()); end
    if (q0.size() == 8)
      for (int i = 0; i < 8; i++) begin
        res = q0[i];
        checks++;
        if (res !== 8 * (i + 1)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, res, 8 * (i + 1)); end
      end
  endtask

  task automatic test_reset_midgroup;
    logic signed [31:0] res;
    int n;
    int base;
    base = q0.size();
    drive0(fill(1), 1'b1, 1'b0);
    drive0(fill(1), 1'b1, 1'b0);
    NRST = 1'b0;
    tick();
    checks += 2;
    if (b0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", b0.OUT_VALID); end
    if (b0.IN_READY !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", b0.IN_READY); end
    NRST = 1'b1;
    drive0(fill(2), 1'b1, 1'b1);
    wait0(n);
    res = b0.RES;
    checks += 2;
    if (res !== 16) begin errors++; $display("FAIL midreset_sum: got %0d expected 16", res); end
    if (n !== 4) begin errors++; $display("FAIL midreset_latency: got %0d expected 4", n); end
    tick();
    checks++;
    if (q0.size() - base !== 1) begin errors++; $display("FAIL midreset_count: got %0d expected 1", q0.size() - base); end
  endtask

  task automatic test_saturation;
    logic signed [31:0] res;
    int n;
    drive1(fill(-1), 1'b0, 1'b0);
    wait1(n);
    res = b1.RES;
    checks += 2;
    if (n !== 1) begin errors++; $display("FAIL lat0_latency: got %0d expected 1", n); end
    if (res !== -8) begin errors++; $display("FAIL lat0_sum: got %0d expected -8", res); end
    tick();
    drive1(fill(127), 1'b1, 1'b0);
    drive1(fill(127), 1'b1, 1'b0);
    drive1(fill(127), 1'b1, 1'b1);
    wait1(n);
    res = b1.RES;
    checks += 3;
    if (n !== 1) begin errors++; $display("FAIL sat_latency: got %0d expected 1", n); end
    if (res !== 2047) begin errors++; $display("FAIL sat_pos: got %0d expected 2047", res); end
    if (b1.OUT_OVF !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b expected 1", b1.OUT_OVF); end
    tick();
    drive1(fill(1), 1'b1, 1'b1);
    wait1(n);
    res = b1.RES;
    checks += 2;
    if (res !== 8) begin errors++; $display("FAIL sat_next: got %0d expected 8", res); end
    if (b1.OUT_OVF !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b expected 0", b1.OUT_OVF); end
    tick();
    drive1(fill(-128), 1'b1, 1'b0);
    drive1(fill(-128), 1'b1, 1'b0);
    drive1(fill(-128), 1'b1, 1'b1);
    wait1(n);
    res = b1.RES;
    checks += 2;
    if (res !== -2048) begin errors++; $display("FAIL sat_neg: got %0d expected -2048", res); end
    if (b1.OUT_OVF !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %b expected 1", b1.OUT_OVF); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_accumulate();
    test_back_to_back();
    test_reset_midgroup();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
